// File: rtl/p2tank_sprite_fetch.sv
// p2tank_sprite_fetch: per-scanline fetch of one tank sprite row from the
// 4096x8 sprite ROM into a double-buffered line buffer, with rotation by the
// tank heading, plus a one-cycle pixel lookup for the VGA compositor.
// Optional build macro: P2TANK_FETCH_OVERRUN_EN adds the overrun_cnt output,
// a saturating count of line_start pulses that arrive while a fetch is busy.
module p2tank_sprite_fetch #(
    parameter int         SPR_DIM     = 64,
    parameter int         ADDR_W      = 12,
    parameter int         COORD_W     = 10,
    parameter logic [7:0] TRANSPARENT = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               line_start,
    input  logic [COORD_W-1:0] line_y,
    input  logic [COORD_W-1:0] spr_x,
    input  logic [COORD_W-1:0] spr_y,
    input  logic [1:0]         dir,
    output logic [ADDR_W-1:0]  rom_address,
    output logic               rom_chipselect,
    output logic               rom_clken,
    input  logic [7:0]         rom_readdata,
    input  logic [COORD_W-1:0] pix_x,
    output logic [7:0]         pix_color,
    output logic               pix_valid,
    output logic               busy
`ifdef P2TANK_FETCH_OVERRUN_EN
    ,
    output logic [7:0]         overrun_cnt
`endif
);

    localparam int LOG = ADDR_W / 2;
    localparam logic [LOG-1:0] M = {LOG{1'b1}};

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [LOG-1:0]     row_q, col_q, cap_col;
    logic [1:0]         dir_q;
    logic [COORD_W-1:0] disp_x;
    logic               front_sel;   // 0: buf_a is front, 1: buf_b is front
    logic               front_full;
    logic               back_done;
    logic               cap_pend;
    logic [7:0]         buf_a [SPR_DIM];
    logic [7:0]         buf_b [SPR_DIM];

    logic [COORD_W-1:0] row_full;
    logic               row_in_range;
    logic [LOG-1:0]     src_r, src_c;
    logic [COORD_W-1:0] d;
    logic               d_in_range;
    logic [7:0]         front_byte;

    assign row_full     = line_y - spr_y;
    assign row_in_range = (row_full < COORD_W'(SPR_DIM));
    assign d            = pix_x - disp_x;
    assign d_in_range   = (d < COORD_W'(SPR_DIM));
    assign front_byte   = front_sel ? buf_b[d[LOG-1:0]] : buf_a[d[LOG-1:0]];

    // Rotation: map the display-space (row, col) onto the ROM source pixel
    always_comb begin
        src_r = row_q;
        src_c = col_q;
        case (dir_q)
            2'd0: begin src_r = row_q;         src_c = col_q;         end
            2'd1: begin src_r = M - col_q;     src_c = row_q;         end
            2'd2: begin src_r = M - row_q;     src_c = M - col_q;     end
            default: begin src_r = col_q;      src_c = M - row_q;     end
        endcase
    end

    // Next-state and ROM strobe decode; line_start overrides any state
    always_comb begin
        state_d        = state_q;
        rom_chipselect = 1'b0;
        busy           = 1'b0;
        case (state_q)
            FETCH: begin
                busy           = 1'b1;
                rom_chipselect = 1'b1;
                if (col_q == M) state_d = DRAIN;
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (line_start) state_d = row_in_range ? FETCH : IDLE;
        rom_clken   = rom_chipselect;
        rom_address = rom_chipselect ? {src_r, src_c} : '0;
    end

    // State register, line latches, buffer bookkeeping and capture pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            cap_col    <= '0;
            dir_q      <= 2'd0;
            disp_x     <= '0;
            front_sel  <= 1'b0;
            front_full <= 1'b0;
            back_done  <= 1'b0;
            cap_pend   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (line_start) begin
                // A half-filled back buffer becomes an empty front buffer
                front_sel  <= ~front_sel;
                front_full <= back_done;
                back_done  <= 1'b0;
                disp_x     <= spr_x;
                row_q      <= row_full[LOG-1:0];
                dir_q      <= dir;
                col_q      <= '0;
                cap_pend   <= 1'b0;
            end else begin
                cap_pend <= (state_q == FETCH);
                cap_col  <= col_q;
                if (state_q == FETCH) col_q <= col_q + 1'b1;
                if (state_q == DRAIN) back_done <= 1'b1;
            end
        end
    end

    // Back-buffer write of the byte returned one cycle after its address
    always_ff @(posedge clk) begin
        if (!reset && !line_start && cap_pend) begin
            if (front_sel) buf_a[cap_col] <= rom_readdata;
            else           buf_b[cap_col] <= rom_readdata;
        end
    end

    // Registered pixel lookup; unsigned d clips both screen edges
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_color <= 8'h00;
            pix_valid <= 1'b0;
        end else if (front_full && d_in_range && front_byte != TRANSPARENT) begin
            pix_color <= front_byte;
            pix_valid <= 1'b1;
        end else begin
            pix_color <= 8'h00;
            pix_valid <= 1'b0;
        end
    end

`ifdef P2TANK_FETCH_OVERRUN_EN
    // Saturating count of line_start pulses that cut a fetch short
    always_ff @(posedge clk) begin
        if (reset) overrun_cnt <= 8'h00;
        else if (line_start && busy && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'h01;
    end
`endif

endmodule

// File: tb/tb_p2tank_sprite_fetch.sv
// Directed bench for p2tank_sprite_fetch. The ROM model returns addr[7:0]
// except address 330 (row 5, column 10, heading up), which holds a
// transparent byte. Sprite left edge is 200 and top edge 100 throughout.
module tb_p2tank_sprite_fetch;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       line_start = 1'b0;
  logic [9:0] line_y = '0;
  logic [9:0] spr_x = '0;
  logic [9:0] spr_y = '0;
  logic [1:0] dir = '0;
  logic [11:0] rom_address;
  logic       rom_chipselect;
  logic       rom_clken;
  logic [7:0] rom_readdata = '0;
  logic [9:0] pix_x = '0;
  logic [7:0] pix_color;
  logic       pix_valid;
  logic       busy;
`ifdef P2TANK_FETCH_OVERRUN_EN
  logic [7:0] overrun_cnt;
`endif

  logic [7:0] rom_mem [4096];

  int tests = 0;
  int fails = 0;

  p2tank_sprite_fetch dut (
    .clk(clk),
    .reset(reset),
    .line_start(line_start),
    .line_y(line_y),
    .spr_x(spr_x),
    .spr_y(spr_y),
    .dir(dir),
    .rom_address(rom_address),
    .rom_chipselect(rom_chipselect),
    .rom_clken(rom_clken),
    .rom_readdata(rom_readdata),
    .pix_x(pix_x),
    .pix_color(pix_color),
    .pix_valid(pix_valid),
    .busy(busy)
`ifdef P2TANK_FETCH_OVERRUN_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  // clock
  always #5 clk = ~clk;

  // synchronous ROM, one clock of read latency
  always @(posedge clk) begin
    if (rom_chipselect && rom_clken) rom_readdata <= rom_mem[rom_address];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_line(input int y, input int d);
    line_y = 10'(y);
    spr_y = 10'd100;
    spr_x = 10'd200;
    dir = 2'(d);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic pix_at(input string tag, input int off, input int col, input int vld);
    pix_x = 10'(200 + off);
    tick();
    check({tag, "_color"}, {24'd0, pix_color}, col);
    check({tag, "_valid"}, {31'd0, pix_valid}, vld);
  endtask

  task automatic sweep(output int hits, output int cs_hits);
    hits = 0;
    cs_hits = 0;
    for (int p = -2; p <= 66; p++) begin
      pix_x = 10'(200 + p);
      tick();
      if (pix_valid) hits++;
      if (rom_chipselect) cs_hits++;
    end
  endtask

  int bc;
  int hits;
  int cs_hits;

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = i[7:0];
    rom_mem[330] = 8'h00;

    // reset
    repeat (3) tick();
    reset = 1'b0;
    check("rst_addr", {20'd0, rom_address}, 0);
    check("rst_cs", {31'd0, rom_chipselect}, 0);
    check("rst_clken", {31'd0, rom_clken}, 0);
    check("rst_color", {24'd0, pix_color}, 0);
    check("rst_valid", {31'd0, pix_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
`ifdef P2TANK_FETCH_OVERRUN_EN
    check("rst_ovr", {24'd0, overrun_cnt}, 0);
`endif

    // heading up, row 5: addresses 320..383, busy for 65 cycles
    do_line(105, 0);
    bc = 0;
    for (int c = 0; c < 64; c++) begin
      check("addr_d0", {20'd0, rom_address}, 320 + c);
      check("cs_d0", {31'd0, rom_chipselect & rom_clken}, 1);
      if (busy) bc++;
      tick();
    end
    check("cs_drain", {31'd0, rom_chipselect}, 0);
    while (busy && bc < 200) begin
      bc++;
      tick();
    end
    check("busy_len", bc, 65);

    // heading right, row 5; display the heading-up line meanwhile
    do_line(105, 1);
    check("addr_d1_0", {20'd0, rom_address}, 63 * 64 + 5);
    pix_x = 10'd203;
    tick();
    check("addr_d1_1", {20'd0, rom_address}, 62 * 64 + 5);
    check("pix3_color", {24'd0, pix_color}, 8'h43);
    check("pix3_valid", {31'd0, pix_valid}, 1);
    pix_at("pix0", 0, 8'h40, 1);
    pix_at("pix9", 9, 8'h49, 1);
    pix_at("pix10_transp", 10, 0, 0);
    pix_at("pix11", 11, 8'h4B, 1);
    pix_at("pix63", 63, 8'h7F, 1);
    pix_at("pix_left", -1, 0, 0);
    pix_at("pix64", 64, 0, 0);
    wait_idle();

    // heading down: first source pixel is (58, 63); heading-right column 0 was address 4037
    do_line(105, 2);
    check("addr_d2_0", {20'd0, rom_address}, 58 * 64 + 63);
    pix_at("pix_d1", 0, 8'hC5, 1);
    wait_idle();

    // heading left: first source pixel is (0, 58)
    do_line(105, 3);
    check("addr_d3_0", {20'd0, rom_address}, 58);
    wait_idle();

    // row above the sprite: no ROM access; heading-left line is displayed
    do_line(99, 0);
    check("above_busy", {31'd0, busy}, 0);
    pix_at("pix_d3", 0, 8'h3A, 1);
    cs_hits = 0;
    for (int i = 0; i < 70; i++) begin
      if (rom_chipselect) cs_hits++;
      tick();
    end
    check("above_cs", cs_hits, 0);

    // row below the sprite: no ROM access; line after no-fetch is empty
    do_line(164, 0);
    check("below_busy", {31'd0, busy}, 0);
    sweep(hits, cs_hits);
    check("below_cs", cs_hits, 0);
    check("empty_line_valid", hits, 0);

    // overrun at column 29: restart on row 6, next line empty
`ifdef P2TANK_FETCH_OVERRUN_EN
    check("ovr_before", {24'd0, overrun_cnt}, 0);
`endif
    do_line(105, 0);
    repeat (29) tick();
    check("addr_col29", {20'd0, rom_address}, 5 * 64 + 29);
    do_line(106, 0);
    check("addr_restart", {20'd0, rom_address}, 6 * 64);
`ifdef P2TANK_FETCH_OVERRUN_EN
    check("ovr_one", {24'd0, overrun_cnt}, 1);
`endif
    sweep(hits, cs_hits);
    check("overrun_line_valid", hits, 0);
    wait_idle();
    do_line(0, 0);
    pix_at("pix_row6", 0, 8'h80, 1);

`ifdef P2TANK_FETCH_OVERRUN_EN
    // saturation: one idle start then 300 starts while busy
    for (int i = 0; i < 301; i++) do_line(105, 0);
    check("ovr_sat", {24'd0, overrun_cnt}, 8'hFF);
    wait_idle();
`endif

    // reset at column 20
    do_line(105, 0);
    repeat (20) tick();
    check("addr_col20", {20'd0, rom_address}, 5 * 64 + 20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_cs", {31'd0, rom_chipselect}, 0);
    do_line(0, 0);
    sweep(hits, cs_hits);
    check("post_rst_line1", hits, 0);
    do_line(105, 0);
    sweep(hits, cs_hits);
    check("post_rst_line2", hits, 0);
    wait_idle();
    do_line(0, 0);
    pix_at("post_rst_pix3", 3, 8'h43, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
